// File: rtl/cic3_ctrl_pkg.sv
// Shared types and helpers for the CIC3 conversion sequencer.
package cic3_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACQ    = 2'd2
  } ctrl_state_e;

  // Accumulator holds 2^avg_log2 full-scale samples without overflow.
  function automatic int acc_width(input int numbits, input int avg_log2);
    return numbits + avg_log2;
  endfunction

endpackage

// File: rtl/cic3_conv_ctrl.sv
// Conversion sequencer for the CIC3 decimator: releases the filter, discards
// settling outputs, averages 2^AVG_LOG2 decimated samples, hands off via valid/ready.
module cic3_conv_ctrl
  import cic3_ctrl_pkg::*;
#(
  parameter int DECIMATION_FACTOR = 256,
  parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
  parameter int NUMBITS           = 3*CLOCK_WIDTH+1,
  parameter int SETTLE_SAMPLES    = 4,
  parameter int AVG_LOG2          = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               continuous,
  input  logic               abort,
  input  logic [NUMBITS-1:0] cic_out,
  output logic               cic_rst_n,
  output logic               mod_en,
  output logic [NUMBITS-1:0] result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy,
  output logic               overrun
);

  localparam int ACC_W   = acc_width(NUMBITS, AVG_LOG2);
  localparam int AVG_N   = 1 << AVG_LOG2;
  localparam int CNT_MAX = (SETTLE_SAMPLES > AVG_N - 1) ? SETTLE_SAMPLES : AVG_N - 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CLOCK_WIDTH-1:0] TICK_PH     = CLOCK_WIDTH'(DECIMATION_FACTOR/2 - 1);
  localparam logic [CNT_W-1:0]       SETTLE_LAST = CNT_W'(SETTLE_SAMPLES);
  localparam logic [CNT_W-1:0]       ACQ_LAST    = CNT_W'(AVG_N - 1);

  ctrl_state_e              state_q, state_d;
  logic [CLOCK_WIDTH-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic                     mode_q, mode_d;
  logic [NUMBITS-1:0]       result_q, result_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;
  logic                     cic_rst_n_q, cic_rst_n_d;
  logic                     mod_en_q, mod_en_d;

  logic                     tick;
  logic                     done;
  logic                     accept;
  logic [ACC_W-1:0]         acc_sum;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    result_d  = result_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    done      = 1'b0;
    tick      = (phase_q == TICK_PH);
    accept    = valid_q & result_ready;
    acc_sum   = acc_q + ACC_W'(cic_out);

    // The tick half a period after release precedes the filter's first output
    // update, so SETTLE counts SETTLE_SAMPLES+1 ticks before acquiring.
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = SETTLE;
          mode_d    = continuous;
          overrun_d = 1'b0;
        end
      end
      SETTLE: begin
        phase_d = phase_q + CLOCK_WIDTH'(1);
        if (tick) begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ACQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ACQ: begin
        phase_d = phase_q + CLOCK_WIDTH'(1);
        if (tick) begin
          if (cnt_q == ACQ_LAST) begin
            done  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
            if (!mode_q) state_d = IDLE;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      done    = 1'b0;
    end
    if (state_d == IDLE) begin
      phase_d = '0;
      cnt_d   = '0;
      acc_d   = '0;
    end

    // A completion may load together with an accept; otherwise it is dropped.
    if (done) begin
      if (!valid_q || accept) begin
        result_d = NUMBITS'(acc_sum >> AVG_LOG2);
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end

    cic_rst_n_d = (state_d != IDLE);
    mod_en_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mode_q      <= 1'b0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      cic_rst_n_q <= 1'b0;
      mod_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      cic_rst_n_q <= cic_rst_n_d;
      mod_en_q    <= mod_en_d;
    end
  end

  assign cic_rst_n    = cic_rst_n_q;
  assign mod_en       = mod_en_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cic3_conv_ctrl.sv
// Bench for cic3_conv_ctrl: time-based behavioural model compared every cycle,
// plus directed scenarios with hand-computed latencies and results.
module tb_cic3_conv_ctrl;

  localparam int D  = 256;
  localparam int NB = 25;
  localparam int S  = 4;
  localparam int AL = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, continuous, abort, result_ready;
  logic [NB-1:0] cic_out;
  logic          cic_rst_n, mod_en, result_valid, busy, overrun;
  logic [NB-1:0] result;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  cic3_conv_ctrl #(
    .DECIMATION_FACTOR(D),
    .SETTLE_SAMPLES(S),
    .AVG_LOG2(AL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .continuous(continuous),
    .abort(abort),
    .cic_out(cic_out),
    .cic_rst_n(cic_rst_n),
    .mod_en(mod_en),
    .result(result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy(busy),
    .overrun(overrun)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Filter stand-in: output value changes once per decimation period.
  logic [NB-1:0] pat [8];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) cic_out = pat[(cyc / D) % 8];

  // Behavioural model: edges since start decide captures.
  bit            m_busy, m_mode, m_valid, m_ovr;
  logic [NB-1:0] m_result;
  int            m_t, m_n;
  longint        m_sum;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_mode <= 1'b0; m_valid <= 1'b0; m_ovr <= 1'b0;
      m_result <= '0; m_t <= 0; m_n <= 0; m_sum <= 0;
    end else begin : mdl
      bit b_n, md_n, v_n, o_n, done;
      int t_n, n_n, j;
      longint s_n, avg;
      logic [NB-1:0] r_n;
      b_n = m_busy; md_n = m_mode; v_n = m_valid; o_n = m_ovr; r_n = m_result;
      t_n = m_t; n_n = m_n; s_n = m_sum; done = 1'b0; avg = 0;
      if (!m_busy) begin
        if (start && !abort) begin
          b_n = 1'b1; md_n = continuous; o_n = 1'b0; t_n = 0; n_n = 0; s_n = 0;
        end
      end else if (abort) begin
        b_n = 1'b0; n_n = 0; s_n = 0;
      end else begin
        t_n = m_t + 1;
        j = t_n / D;
        if ((t_n % D) == D/2 && j > S) begin
          s_n = s_n + longint'(cic_out);
          n_n++;
          if (n_n == (1 << AL)) begin
            done = 1'b1; avg = s_n / (1 << AL); s_n = 0; n_n = 0;
            if (!m_mode) b_n = 1'b0;
          end
        end
      end
      if (done) begin
        if (!m_valid || result_ready) begin r_n = NB'(avg); v_n = 1'b1; end
        else o_n = 1'b1;
      end else if (m_valid && result_ready) begin
        v_n = 1'b0;
      end
      m_busy <= b_n; m_mode <= md_n; m_valid <= v_n; m_ovr <= o_n; m_result <= r_n;
      m_t <= t_n; m_n <= n_n; m_sum <= s_n;
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1 && cmp_en) begin
      chk("cmp busy", busy, m_busy);
      chk("cmp cic_rst_n", cic_rst_n, m_busy);
      chk("cmp mod_en", mod_en, m_busy);
      chk("cmp result_valid", result_valid, m_valid);
      chk("cmp result", result, m_result);
      chk("cmp overrun", overrun, m_ovr);
    end
  end

  task automatic do_start(input bit cont);
    @(negedge clk);
    start = 1'b1; continuous = cont;
    @(negedge clk);
    start = 1'b0; continuous = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      n++;
      if (result_valid) break;
    end
  endtask

  task automatic accept_one();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    int n;
    logic [NB-1:0] first_val;
    reset_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    result_ready = 1'b0; cic_out = '0;
    for (int i = 0; i < 8; i++) pat[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst cic_rst_n", cic_rst_n, 0);
    chk("rst mod_en", mod_en, 0);
    chk("rst result_valid", result_valid, 0);
    chk("rst result", result, 0);
    chk("rst overrun", overrun, 0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Single-shot, full-scale constant input.
    for (int i = 0; i < 8; i++) pat[i] = NB'(1 << 24);
    do_start(1'b0);
    wait_valid(n);
    chk("A latency", n, 2176);
    chk("A result", result, 1 << 24);
    chk("A busy", busy, 0);
    chk("A cic_rst_n", cic_rst_n, 0);
    accept_one();
    chk("A accepted", result_valid, 0);

    // Mid-scale with truncation; start while busy is ignored.
    for (int i = 0; i < 8; i++) pat[i] = (i % 2 == 0) ? NB'((1 << 23) + 1) : NB'((1 << 23) - 2);
    do_start(1'b0);
    repeat (100) @(negedge clk);
    start = 1'b1; continuous = 1'b1;
    @(negedge clk);
    start = 1'b0; continuous = 1'b0;
    wait_valid(n);
    chk("B latency", n + 101, 2176);
    chk("B result", result, (1 << 23) - 1);
    chk("B still single", busy, 0);
    accept_one();

    // Continuous, ready held high.
    for (int i = 0; i < 8; i++) pat[i] = NB'(1000 * (i + 1));
    result_ready = 1'b1;
    do_start(1'b1);
    wait_valid(n);
    chk("C latency", n, 2176);
    @(negedge clk);
    chk("C pulse", result_valid, 0);
    wait_valid(n);
    chk("C interval", n + 1, 1024);
    chk("C overrun", overrun, 0);
    chk("C busy", busy, 1);
    do_abort();
    chk("C abort busy", busy, 0);
    chk("C abort cic_rst_n", cic_rst_n, 0);
    result_ready = 1'b0;

    // Continuous, ready held low: overrun, then simultaneous accept+load.
    do_start(1'b1);
    wait_valid(n);
    chk("D latency", n, 2176);
    first_val = m_result;
    repeat (1100) @(negedge clk);
    chk("D overrun", overrun, 1);
    chk("D result held", result, first_val);
    chk("D valid held", result_valid, 1);
    accept_one();
    chk("D accepted", result_valid, 0);
    repeat (1970) @(negedge clk);
    chk("D reload", result_valid, 1);
    accept_one();
    chk("D simult valid", result_valid, 1);
    do_abort();
    chk("D abort valid kept", result_valid, 1);

    // Abort mid-acquisition, then a full-latency conversion.
    for (int i = 0; i < 8; i++) pat[i] = NB'(1 << 24);
    do_start(1'b0);
    chk("E overrun cleared", overrun, 0);
    repeat (1500) @(negedge clk);
    do_abort();
    chk("E abort busy", busy, 0);
    chk("E abort cic_rst_n", cic_rst_n, 0);
    chk("E abort mod_en", mod_en, 0);
    chk("E abort valid kept", result_valid, 1);
    accept_one();
    do_start(1'b0);
    wait_valid(n);
    chk("E latency", n, 2176);
    chk("E result", result, 1 << 24);
    accept_one();

    // Asynchronous reset during SETTLE.
    do_start(1'b0);
    repeat (300) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("F busy", busy, 0);
    chk("F cic_rst_n", cic_rst_n, 0);
    chk("F mod_en", mod_en, 0);
    chk("F result_valid", result_valid, 0);
    chk("F result", result, 0);
    chk("F overrun", overrun, 0);
    @(negedge clk);
    reset_n = 1'b1;
    do_start(1'b0);
    wait_valid(n);
    chk("F latency", n, 2176);
    chk("F result after reset", result, 1 << 24);
    accept_one();

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
